// File: rtl/nonce_tx_scheduler_pkg.sv
// Shared types and constants for the nonce transmit scheduler: FSM state
// encoding, frame geometry and the core-index byte format.
package nonce_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam int FRAME_BYTES = 5;
  localparam int NONCE_BYTES = 4;
  localparam int CORE_IDX_W  = 3;

  // First byte of every frame: core index in the low 3 bits, upper 5 bits zero.
  function automatic logic [7:0] core_byte(input logic [CORE_IDX_W-1:0] idx);
    return {5'b00000, idx};
  endfunction

endpackage

// File: rtl/nonce_tx_scheduler_if.sv
// Bundle of miner-side, uart-side and status signals of the nonce scheduler.
interface nonce_tx_if #(
  parameter int NUM_CORES   = 4,
  parameter int NONCE_WIDTH = 32
);
  import nonce_tx_scheduler_pkg::*;

  // Handshakes: found[i] is a one-cycle valid with no ready; a result is always
  // taken into its slot or, if the slot is full, dropped and flagged in overflow.
  // tx_wr_en is a one-cycle strobe; the next strobe waits until tx_busy, sampled
  // after a settle delay, reads 0.
  logic [NUM_CORES-1:0]             found;
  logic [NUM_CORES*NONCE_WIDTH-1:0] nonce_in;
  logic                             tx_busy;
  logic [7:0]                       tx_data;
  logic                             tx_wr_en;
  logic [NUM_CORES-1:0]             pending;
  logic [NUM_CORES-1:0]             overflow;
  logic [2:0]                       active_core;
  logic [31:0]                      frames_sent;
  logic                             busy;
  state_e                           fsm_state;

  modport master (
    output found, nonce_in, tx_busy,
    input  tx_data, tx_wr_en, pending, overflow, active_core, frames_sent, busy, fsm_state
  );

  modport slave (
    input  found, nonce_in, tx_busy,
    output tx_data, tx_wr_en, pending, overflow, active_core, frames_sent, busy, fsm_state
  );

endinterface

// File: rtl/nonce_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: pointer register plus a combinational search that
// starts at the core after the last one granted.
module rr_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic                 advance,
  output logic [NUM_CORES-1:0] grant,
  output logic [2:0]           grant_idx
);

  logic [2:0] ptr_q;
  logic       hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= 3'd0;
    end else if (advance) begin
      ptr_q <= (int'(grant_idx) == NUM_CORES - 1) ? 3'd0 : grant_idx + 3'd1;
    end
  end

  always_comb begin
    grant     = '0;
    grant_idx = 3'd0;
    hit       = 1'b0;
    for (int off = 0; off < NUM_CORES; off++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!hit && req[i] && (i == (int'(ptr_q) + off) % NUM_CORES)) begin
          hit       = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/nonce_tx_scheduler.sv
// Captures winning nonces from several cores and serialises each one as a
// 5-byte frame (core index, nonce MSB first) onto a shared uart byte port.
module nonce_tx_scheduler
  import nonce_tx_scheduler_pkg::*;
#(
  parameter int NUM_CORES     = 4,
  parameter int NONCE_WIDTH   = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  nonce_tx_if.slave  bus
);

  localparam int FW = FRAME_BYTES * 8;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (NUM_CORES < 1 || NUM_CORES > 8) begin : g_bad_cores
    $error("nonce_tx_scheduler: NUM_CORES must be in 1..8");
  end
  if (NONCE_WIDTH != NONCE_BYTES * 8) begin : g_bad_width
    $error("nonce_tx_scheduler: NONCE_WIDTH must be 32");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("nonce_tx_scheduler: SETTLE_CYCLES must be at least 1");
  end

  state_e                 state, next_state;
  logic [NONCE_WIDTH-1:0] slot_q [NUM_CORES];
  logic [NUM_CORES-1:0]   pending_q, overflow_q, grant;
  logic [2:0]             grant_idx, active_q, byte_idx;
  logic [NONCE_WIDTH-1:0] sel_nonce;
  logic [FW-1:0]          frame_q;
  logic [SW-1:0]          settle_cnt;
  logic [7:0]             tx_data_q;
  logic [31:0]            frames_q;
  logic                   arb_fire, settle_done;
  logic                   tx_wr_en, busy;
  logic [7:0]             tx_data;

  assign arb_fire    = (state == S_ARB);
  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (pending_q),
    .advance   (arb_fire),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) sel_nonce = slot_q[i];
    end
  end

  // A slot granted this cycle counts as empty, so a same-cycle found refills it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      overflow_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (bus.found[i]) begin
          if (!pending_q[i] || (arb_fire && grant[i])) begin
            slot_q[i]    <= bus.nonce_in[i*NONCE_WIDTH +: NONCE_WIDTH];
            pending_q[i] <= 1'b1;
          end else begin
            overflow_q[i] <= 1'b1;
          end
        end else if (arb_fire && grant[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (|pending_q) next_state = S_ARB;
      S_ARB:    next_state = S_LOAD;
      S_LOAD:   next_state = S_SETTLE;
      S_SETTLE: if (settle_done) next_state = S_WAIT;
      S_WAIT:   if (!bus.tx_busy) next_state = (byte_idx < 3'(NONCE_BYTES)) ? S_LOAD : S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    tx_wr_en = (state == S_LOAD);
    tx_data  = (state == S_LOAD) ? frame_q[FW-1 -: 8] : tx_data_q;
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_q    <= '0;
      active_q   <= 3'd0;
      byte_idx   <= 3'd0;
      settle_cnt <= '0;
      tx_data_q  <= 8'd0;
      frames_q   <= 32'd0;
    end else begin
      unique case (state)
        S_ARB: begin
          frame_q  <= {core_byte(grant_idx), sel_nonce};
          active_q <= grant_idx;
          byte_idx <= 3'd0;
        end
        S_LOAD: begin
          frame_q    <= frame_q << 8;
          tx_data_q  <= frame_q[FW-1 -: 8];
          settle_cnt <= '0;
        end
        S_SETTLE: if (!settle_done) settle_cnt <= settle_cnt + 1'b1;
        S_WAIT:   if (!bus.tx_busy && byte_idx < 3'(NONCE_BYTES)) byte_idx <= byte_idx + 3'd1;
        S_DONE:   frames_q <= frames_q + 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.tx_data     = tx_data;
  assign bus.tx_wr_en    = tx_wr_en;
  assign bus.pending     = pending_q;
  assign bus.overflow    = overflow_q;
  assign bus.active_core = active_q;
  assign bus.frames_sent = frames_q;
  assign bus.busy        = busy;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_nonce_tx_scheduler.sv
// Directed bench for nonce_tx_scheduler: uart busy model, byte scoreboard and
// hand-computed frames for each scenario.
module tb_nonce_tx_scheduler;
  import nonce_tx_scheduler_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic stuck = 1'b0;
  int   busy_cnt = 0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  nonce_tx_if #(.NUM_CORES(4), .NONCE_WIDTH(32)) bus ();

  nonce_tx_scheduler #(.NUM_CORES(4), .NONCE_WIDTH(32), .SETTLE_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // uart model: busy for 10 cycles after each write strobe; also records bytes
  always @(negedge clock) begin
    if (bus.tx_wr_en) begin
      got_q.push_back(bus.tx_data);
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.tx_busy = stuck || (busy_cnt != 0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b0;
    bus.found = '0;
    bus.nonce_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse(input logic [3:0] mask, input logic [31:0] n0, input logic [31:0] n1,
                       input logic [31:0] n2, input logic [31:0] n3);
    bus.found = mask;
    bus.nonce_in = {n3, n2, n1, n0};
    @(negedge clock);
    bus.found = '0;
  endtask

  task automatic push_frame(input logic [2:0] core, input logic [31:0] n);
    exp_q.push_back({5'b00000, core});
    exp_q.push_back(n[31:24]);
    exp_q.push_back(n[23:16]);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((bus.busy || bus.pending != 4'b0000) && n < 3000);
    check({tag, "_idle_in_time"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic wait_bytes(input int cnt, input string tag);
    int n = 0;
    while (got_q.size() < cnt && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_bytes_in_time"}, 64'(got_q.size() >= cnt), 64'd1);
  endtask

  // scoreboard: drain and compare recorded bytes against the expected queue
  task automatic check_frames(input string tag);
    check({tag, "_byte_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_byte"}, 64'(g), 64'(e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    int n;
    bus.found = '0;
    bus.nonce_in = '0;

    // reset values
    repeat (2) @(negedge clock);
    check("rst_tx_wr_en", 64'(bus.tx_wr_en), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_pending", 64'(bus.pending), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_active_core", 64'(bus.active_core), 64'd0);
    check("rst_frames_sent", 64'(bus.frames_sent), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_state", 64'(bus.fsm_state), 64'(S_IDLE));
    reset = 1'b1;
    @(negedge clock);

    // single result, latency to first strobe
    bus.found = 4'b0100;
    bus.nonce_in = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        bus.found = '0;
        check("single_pending_next", 64'(bus.pending), 64'h4);
      end
    end while (!bus.tx_wr_en && lat < 20);
    check("single_latency", 64'(lat), 64'd3);
    wait_idle("single");
    push_frame(3'd2, 32'hDEADBEEF);
    check_frames("single");
    check("single_frames_sent", 64'(bus.frames_sent), 64'd1);
    check("single_active_core", 64'(bus.active_core), 64'd2);
    check("single_pending", 64'(bus.pending), 64'd0);
    check("single_busy", 64'(bus.busy), 64'd0);

    // simultaneous results on cores 0,1,3
    do_reset();
    pulse(4'b1011, 32'h01234567, 32'h89ABCDEF, 32'h0, 32'hCAFEF00D);
    wait_idle("simul");
    push_frame(3'd0, 32'h01234567);
    push_frame(3'd1, 32'h89ABCDEF);
    push_frame(3'd3, 32'hCAFEF00D);
    check_frames("simul");
    check("simul_frames_sent", 64'(bus.frames_sent), 64'd3);
    check("simul_overflow", 64'(bus.overflow), 64'd0);

    // round-robin fairness
    do_reset();
    pulse(4'b0011, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0, 32'h0);
    wait_bytes(1, "rr");
    pulse(4'b0001, 32'hC0C0C0C0, 32'h0, 32'h0, 32'h0);
    wait_idle("rr");
    push_frame(3'd0, 32'hA0A0A0A0);
    push_frame(3'd1, 32'hB1B1B1B1);
    push_frame(3'd0, 32'hC0C0C0C0);
    check_frames("rr");
    check("rr_frames_sent", 64'(bus.frames_sent), 64'd3);

    // overflow on core 1
    do_reset();
    pulse(4'b0001, 32'h11223344, 32'h0, 32'h0, 32'h0);
    wait_bytes(1, "ovf");
    pulse(4'b0010, 32'h0, 32'h55667788, 32'h0, 32'h0);
    @(negedge clock);
    pulse(4'b0010, 32'h0, 32'h99AABBCC, 32'h0, 32'h0);
    check("ovf_flag_set", 64'(bus.overflow), 64'h2);
    wait_idle("ovf");
    push_frame(3'd0, 32'h11223344);
    push_frame(3'd1, 32'h55667788);
    check_frames("ovf");
    check("ovf_flag_sticky", 64'(bus.overflow), 64'h2);

    // capture in the grant cycle of the same core
    do_reset();
    pulse(4'b0001, 32'h0BADF00D, 32'h0, 32'h0, 32'h0);
    n = 0;
    while (bus.fsm_state != S_ARB && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("grant_reached_arb", 64'(bus.fsm_state), 64'(S_ARB));
    pulse(4'b0001, 32'hFEEDFACE, 32'h0, 32'h0, 32'h0);
    wait_idle("grant");
    push_frame(3'd0, 32'h0BADF00D);
    push_frame(3'd0, 32'hFEEDFACE);
    check_frames("grant");
    check("grant_overflow", 64'(bus.overflow), 64'd0);
    check("grant_frames_sent", 64'(bus.frames_sent), 64'd2);

    // reset in the middle of a frame
    do_reset();
    pulse(4'b0001, 32'h13579BDF, 32'h0, 32'h0, 32'h0);
    wait_bytes(2, "mid");
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx_wr_en", 64'(bus.tx_wr_en), 64'd0);
    check("mid_rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("mid_rst_pending", 64'(bus.pending), 64'd0);
    check("mid_rst_active_core", 64'(bus.active_core), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h13);
    check_frames("mid_abandoned");
    pulse(4'b1000, 32'h0, 32'h0, 32'h0, 32'h2468ACE0);
    wait_idle("mid");
    push_frame(3'd3, 32'h2468ACE0);
    check_frames("mid_clean");
    check("mid_frames_sent", 64'(bus.frames_sent), 64'd1);

    // uart busy held high: FSM parks in WAIT, captures continue
    do_reset();
    stuck = 1'b1;
    pulse(4'b0010, 32'h0, 32'h5A5A5A5A, 32'h0, 32'h0);
    repeat (40) @(negedge clock);
    check("stuck_state", 64'(bus.fsm_state), 64'(S_WAIT));
    check("stuck_busy", 64'(bus.busy), 64'd1);
    check("stuck_tx_data_held", 64'(bus.tx_data), 64'h01);
    check("stuck_one_byte", 64'(got_q.size()), 64'd1);
    pulse(4'b0100, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0);
    check("stuck_capture", 64'(bus.pending), 64'h4);
    stuck = 1'b0;
    wait_idle("stuck");
    push_frame(3'd1, 32'h5A5A5A5A);
    push_frame(3'd2, 32'hA5A5A5A5);
    check_frames("stuck");
    check("stuck_frames_sent", 64'(bus.frames_sent), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nonce_tx_scheduler.md
Name: nonce_tx_scheduler

Overview:
Shares the single UART byte transmitter between NUM_CORES hashing cores that report winning nonces. Each core's result is captured into a per-core pending slot. Pending slots are served round-robin. Each served result is sent as a 5-byte frame: core index byte, then the nonce MSB first. The block sits between the miner cores and the uart byte interface (din / wr_en / tx_busy).

Parameters:
NUM_CORES, 4, number of requesting cores (1..8)
NONCE_WIDTH, 32, nonce width in bits; fixed at 4 bytes
SETTLE_CYCLES, 2, cycles to wait after a wr_en pulse before sampling tx_busy

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
found  in  NUM_CORES  per-core one-cycle pulse: nonce valid
nonce_in  in  NUM_CORES*NONCE_WIDTH  packed nonces; core i at [i*32 +: 32]
tx_busy  in  1  uart transmitter busy
tx_data  out  8  byte to uart din
tx_wr_en  out  1  one-cycle write strobe to uart
pending  out  NUM_CORES  slot-occupied flags
overflow  out  NUM_CORES  sticky: a result was dropped for this core
active_core  out  3  index of the core being transmitted
frames_sent  out  32  count of completed frames, wraps at 2^32
busy  out  1  a frame is in progress

Behaviour:
- Reset (reset=0, async): all outputs 0, all slots empty, FSM in IDLE, round-robin pointer 0.
- Capture:
  - found[i]=1 with slot i empty: latch nonce_in[i] and set pending[i] next cycle.
  - found[i]=1 with slot i full: the new value is discarded and overflow[i] is set (sticky until reset).
  - A slot is freed in the cycle the FSM leaves ARB for core i. A found[i] in that same cycle is captured as a new pending entry, with no overflow.
- Arbitration: round-robin. Search starts at last-granted+1 modulo NUM_CORES. After reset the search starts at 0.
- FSM states: IDLE, ARB, LOAD, SETTLE, WAIT, DONE.
  - IDLE: if any pending, go to ARB next cycle; busy=0.
  - ARB: select core k. Copy {k[7:0], nonce_k} into a 40-bit frame register, clear pending[k], set active_core=k and byte index=0. Go to LOAD.
  - LOAD: tx_data = frame[39:32], tx_wr_en=1 for exactly one cycle. Shift the frame register left 8. Go to SETTLE.
  - SETTLE: hold SETTLE_CYCLES cycles, tx_wr_en=0, then go to WAIT.
  - WAIT: stay while tx_busy=1. When tx_busy=0, go to LOAD if byte index<4 (index increments), else go to DONE.
  - DONE: frames_sent+1, go to IDLE.
- busy=1 in every state except IDLE.
- tx_data holds its last value outside LOAD.
- Latency:
  - found pulse to first tx_wr_en: 3 cycles (capture, IDLE→ARB, ARB→LOAD), when the FSM is idle.
  - Minimum frame length: 5*(1+SETTLE_CYCLES+1) + 2 cycles.
- tx_busy held high indefinitely: the FSM stays in WAIT, with no timeout. Captures continue.
- Reset mid-frame: the frame is abandoned, slots are cleared, and no further tx_wr_en is issued.
- frames_sent wraps from 0xFFFFFFFF to 0.
- Only NUM_CORES ≤ 8 is legal. Elaboration fails otherwise.

Decomposition:
- Shared package: FSM state enum, FRAME_BYTES=5, NONCE_BYTES=4, and the core-index byte format (upper 5 bits zero).
- Sub-module rr_arbiter: NUM_CORES request vector in; one-hot grant and encoded index out; advance input updates the pointer. Purely the pointer register plus a combinational search.

Test Plan:
- Single result: found[2]=1, nonce 0xDEADBEEF, tx_busy modeled 10 cycles per byte -> wr_en bytes 02,DE,AD,BE,EF in order. frames_sent=1, pending=0, busy returns 0.
- Simultaneous: found=4'b1011 in one cycle with distinct nonces -> frames sent for cores 0,1,3 in that order. frames_sent=3, no overflow.
- Round-robin fairness: core 0 re-asserts found after each grant while core 1 has a pending result -> frame order 0,1,0, not 0,0.
- Overflow: found[1] twice, 2 cycles apart, while the FSM is busy with core 0 -> only the first nonce for core 1 is transmitted. overflow=4'b0010 stays set.
- Grant-cycle capture: found[0] pulses in the ARB cycle granting core 0 -> two frames for core 0 are sent, overflow[0]=0.
- Reset mid-frame: async reset low after the 2nd byte -> tx_wr_en stays 0, all outputs 0. After release plus one new found[3], a clean frame starting with 03 is sent.
